// File: rtl/sw_conditioner.sv
// Switch input conditioner: per-bit synchronizer, tick-paced debounce, registered
// rise/fall pulses and a sticky event register cleared by a masked write strobe.
module sw_conditioner #(
  parameter int unsigned N_IN         = 18,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 10,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] sw_raw,
  input  logic            clr_en,
  input  logic [N_IN-1:0] clr_mask,
  output logic [N_IN-1:0] sw_stable,
  output logic [N_IN-1:0] sw_rise,
  output logic [N_IN-1:0] sw_fall,
  output logic [N_IN-1:0] sw_event,
  output logic            event_any
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(STABLE_TICKS + 1);

  logic [N_IN-1:0] sync_q [SYNC_STAGES];
  logic [N_IN-1:0] s;

  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            tick;

  logic [DW-1:0]   dcnt_q [N_IN];
  logic [DW-1:0]   dcnt_d [N_IN];

  logic [N_IN-1:0] stable_q, stable_d;
  logic [N_IN-1:0] rise_q, rise_d;
  logic [N_IN-1:0] fall_q, fall_d;
  logic [N_IN-1:0] event_q, event_d;
  logic [N_IN-1:0] clr_sel;
  logic            any_q;

  // Synchronizer chain; the only place metastability is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Free-running prescaler shared by every bit; tick on the terminal count.
  assign tick   = (pcnt_q == PW'(TICK_DIV - 1));
  assign pcnt_d = tick ? '0 : pcnt_q + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

  // Debounce next-state: count ticks of disagreement, any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_IN; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (s[i] == stable_q[i]) begin
        dcnt_d[i] = '0;
      end else if (tick) begin
        if (dcnt_q[i] == DW'(STABLE_TICKS - 1)) begin
          stable_d[i] = s[i];
          dcnt_d[i]   = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Pulse and sticky-event next-state; a set in the same cycle as a clear wins.
  always_comb begin
    rise_d  = stable_d & ~stable_q;
    fall_d  = ~stable_d & stable_q;
    clr_sel = clr_en ? clr_mask : '0;
    event_d = (event_q & ~clr_sel) | rise_d | fall_d;
  end

  // Debounce counters, stable level, pulses and events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) dcnt_q[i] <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      event_q  <= '0;
      any_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_IN; i++) dcnt_q[i] <= dcnt_d[i];
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      event_q  <= event_d;
      any_q    <= |event_d;
    end
  end

  assign sw_stable = stable_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign sw_event  = event_q;
  assign event_any = any_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner with a short prescaler and debounce window.
module tb_sw_conditioner;

  localparam int unsigned N_IN         = 4;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned STABLE_TICKS = 3;
  localparam int unsigned SYNC_STAGES  = 2;
  // Latency window in cycles from a raw edge to the sw_stable change.
  localparam int LAT_MIN = 2 + 8 + 1;
  localparam int LAT_MAX = 2 + 8 + 4;

  logic            clk;
  logic            rst_n;
  logic [N_IN-1:0] sw_raw;
  logic            clr_en;
  logic [N_IN-1:0] clr_mask;
  logic [N_IN-1:0] sw_stable;
  logic [N_IN-1:0] sw_rise;
  logic [N_IN-1:0] sw_fall;
  logic [N_IN-1:0] sw_event;
  logic            event_any;

  int errors = 0;
  int checks = 0;

  sw_conditioner #(
    .N_IN         (N_IN),
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .clr_en    (clr_en),
    .clr_mask  (clr_mask),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_event  (sw_event),
    .event_any (event_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for sw_stable[b] to reach lvl; n is the cycle count, 0 on timeout.
  task automatic wait_bit(input int b, input logic lvl, output int n);
    n = 0;
    for (int c = 1; c <= 20 && n == 0; c++) begin
      step();
      if (sw_stable[b] === lvl) n = c;
    end
  endtask

  logic [16:0] all_out;
  assign all_out = {sw_stable, sw_rise, sw_fall, sw_event, event_any};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    logic bad;
    rst_n    = 1'b0;
    sw_raw   = '0;
    clr_en   = 1'b0;
    clr_mask = '0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // 1: bring all bits high, then async reset mid-cycle.
    sw_raw = 4'hF;
    repeat (20) step();
    check_eq("pre_reset_stable", 32'(sw_stable), 32'hF);
    check_eq("pre_reset_event", 32'(sw_event), 32'hF);
    #3 rst_n = 1'b0;
    #1 check_eq("async_reset_outs", 32'(all_out), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_release_c1", 32'(all_out), 32'h0);
    step();
    check_eq("post_release_c2", 32'(all_out), 32'h0);
    sw_raw = 4'h0;
    repeat (20) step();
    check_eq("no_replay", 32'(all_out), 32'h0);

    // 2: clean press on bit 0.
    sw_raw[0] = 1'b1;
    wait_bit(0, 1'b1, n);
    check_eq("press_latency_ok", 32'(n >= LAT_MIN && n <= LAT_MAX), 32'h1);
    check_eq("press_rise", 32'(sw_rise), 32'h1);
    check_eq("press_fall", 32'(sw_fall), 32'h0);
    check_eq("press_event", 32'(sw_event), 32'h1);
    check_eq("press_any", 32'(event_any), 32'h1);
    step();
    check_eq("press_rise_one_cycle", 32'(sw_rise), 32'h0);

    // 3: bit 1 bounces every 3 cycles, never long enough to be accepted.
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) sw_raw[1] = ~sw_raw[1];
      step();
      if (sw_stable[1] || sw_rise[1] || sw_fall[1]) bad = 1'b1;
    end
    sw_raw[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (sw_stable[1] || sw_rise[1] || sw_fall[1]) bad = 1'b1;
    end
    check_eq("bounce_quiet", 32'(bad), 32'h0);
    check_eq("bounce_event", 32'(sw_event), 32'h1);

    // 4: set bit 1 event cleanly, then clear bits selectively.
    sw_raw[1] = 1'b1;
    wait_bit(1, 1'b1, n);
    check_eq("b1_latency_ok", 32'(n >= LAT_MIN && n <= LAT_MAX), 32'h1);
    check_eq("two_events", 32'(sw_event), 32'h3);
    clr_en = 1'b1; clr_mask = 4'h1;
    step();
    clr_en = 1'b0; clr_mask = 4'h0;
    check_eq("clr_b0_event", 32'(sw_event), 32'h2);
    check_eq("clr_b0_any", 32'(event_any), 32'h1);
    clr_en = 1'b1; clr_mask = 4'h2;
    step();
    clr_en = 1'b0; clr_mask = 4'h0;
    check_eq("clr_b1_event", 32'(sw_event), 32'h0);
    check_eq("clr_b1_any", 32'(event_any), 32'h0);

    // 5: clear held on bit 2 across its accepted transition; the set must win.
    clr_en = 1'b1; clr_mask = 4'h4;
    sw_raw[2] = 1'b1;
    wait_bit(2, 1'b1, n);
    clr_en = 1'b0; clr_mask = 4'h0;
    check_eq("collide_seen", 32'(n != 0), 32'h1);
    check_eq("collide_event", 32'(sw_event), 32'h4);
    check_eq("collide_rise", 32'(sw_rise), 32'h4);
    check_eq("collide_any", 32'(event_any), 32'h1);
    step();
    check_eq("collide_event_held", 32'(sw_event), 32'h4);
    clr_en = 1'b1; clr_mask = 4'h0;
    step();
    clr_en = 1'b0;
    check_eq("clr_mask0_noop", 32'(sw_event), 32'h4);
    clr_en = 1'b1; clr_mask = 4'h4;
    step();
    clr_en = 1'b0; clr_mask = 4'h0;
    check_eq("clr_b2_event", 32'(sw_event), 32'h0);
    check_eq("clr_b2_any", 32'(event_any), 32'h0);

    // 6: release bit 0.
    sw_raw[0] = 1'b0;
    wait_bit(0, 1'b0, n);
    check_eq("release_latency_ok", 32'(n >= LAT_MIN && n <= LAT_MAX), 32'h1);
    check_eq("release_fall", 32'(sw_fall), 32'h1);
    check_eq("release_rise", 32'(sw_rise), 32'h0);
    check_eq("release_event", 32'(sw_event), 32'h1);
    check_eq("release_stable", 32'(sw_stable), 32'h6);
    step();
    check_eq("release_fall_one_cycle", 32'(sw_fall), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
